mult_pipe_nbit: RTL and testbench

- Parametrised, pipelined unsigned N x N multiplier for the FPU mantissa datapath; successor to the fixed 24-bit split multiplier.
- Splits each operand into halves and forms four half-width partial products. Sums them over a 3-stage elastic pipeline with valid/ready handshakes on input and output.
- Sits between exponent/sign pre-processing and the normaliser in the FP multiply path; one new operand pair accepted per cycle when not stalled.

---
 rtl/mult_pipe_nbit.sv | 99 +++++++++
 tb/tb_mult_pipe_nbit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_nbit.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// mult_pipe_nbit : 3-stage elastic unsigned NxN multiplier built from half-width
// partial products. Optional macro MUL_NORM_EN adds norm_hi/mant.   rev 1.0
// -----------------------------------------------------------------------------
module mult_pipe_nbit #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] R
`ifdef MUL_NORM_EN
  ,
  output logic           norm_hi,
  output logic [N-1:0]   mant
`endif
);
  localparam int H = N / 2;

  logic           v1, v2, v3;
  logic           adv1, adv2, adv3;
  logic [N-1:0]   m_lo, m_hi, q_lo, q_hi;
  logic [N-1:0]   pll1, plh1, phl1, phh1;
  logic [N-1:0]   pll2, phh2;
  logic [N:0]     mid2;
  logic [2*N-1:0] sum3;

  // Halves are zero-extended so every partial product is formed at N bits.
  assign m_lo = {{H{1'b0}}, M[H-1:0]};
  assign m_hi = {{H{1'b0}}, M[N-1:H]};
  assign q_lo = {{H{1'b0}}, Q[H-1:0]};
  assign q_hi = {{H{1'b0}}, Q[N-1:H]};

  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = rstn && adv1;
  assign out_valid = v3;

  assign sum3 = {phh2, {N{1'b0}}}
              + {{(H-1){1'b0}}, mid2, {H{1'b0}}}
              + {{N{1'b0}}, pll2};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      pll1 <= m_lo * q_lo;
      plh1 <= m_lo * q_hi;
      phl1 <= m_hi * q_lo;
      phh1 <= m_hi * q_hi;
    end
    if (v1 && adv2) begin
      pll2 <= pll1;
      phh2 <= phh1;
      mid2 <= {1'b0, plh1} + {1'b0, phl1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      R <= '0;
    end else if (v2 && adv3) begin
      R <= sum3;
    end
  end

`ifdef MUL_NORM_EN
  // Top-N mantissa bits for a product in [1,4): shift by one when bit 2N-1 is clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      norm_hi <= 1'b0;
      mant    <= '0;
    end else if (v2 && adv3) begin
      norm_hi <= sum3[2*N-1];
      mant    <= sum3[2*N-1] ? sum3[2*N-1:N] : sum3[2*N-2:N-1];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe_nbit.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for mult_pipe_nbit: N=24 directed/stall/reset cases plus N=8 and
// N=54 sweeps under random backpressure.
module tb_mult_pipe_nbit;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        in_valid, out_ready;
  logic [23:0] M, Q;
  logic        in_ready, out_valid;
  logic [47:0] R;

  logic        iv8, or8, ir8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        iv54, or54, ir54, ov54;
  logic [53:0] a54, b54;
  logic [107:0] r54;

`ifdef MUL_NORM_EN
  logic        norm_hi, nh8, nh54;
  logic [23:0] mant;
  logic [7:0]  mt8;
  logic [53:0] mt54;
`endif

  mult_pipe_nbit #(.N(24)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .M(M), .Q(Q), .out_valid(out_valid), .out_ready(out_ready), .R(R)
`ifdef MUL_NORM_EN
    , .norm_hi(norm_hi), .mant(mant)
`endif
  );

  mult_pipe_nbit #(.N(8)) u8 (
    .clk(clk), .rstn(rstn), .in_valid(iv8), .in_ready(ir8),
    .M(a8), .Q(b8), .out_valid(ov8), .out_ready(or8), .R(r8)
`ifdef MUL_NORM_EN
    , .norm_hi(nh8), .mant(mt8)
`endif
  );

  mult_pipe_nbit #(.N(54)) u54 (
    .clk(clk), .rstn(rstn), .in_valid(iv54), .in_ready(ir54),
    .M(a54), .Q(b54), .out_valid(ov54), .out_ready(or54), .R(r54)
`ifdef MUL_NORM_EN
    , .norm_hi(nh54), .mant(mt54)
`endif
  );

  int            errors = 0;
  int            checks = 0;
  int            n_in, n_out, idx;
  logic          acc;
  logic [127:0]  sb[$];
  logic [23:0]   pm[5];
  logic [23:0]   pq[5];

  localparam int NP8  = 400;
  localparam int NP54 = 200;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One cycle on the N=24 DUT with scoreboard bookkeeping; acc reports input transfer.
  task automatic cyc24(output logic a);
    #1;
    a = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("n24 unexpected output", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) chk("n24 R", 128'(R), sb.pop_front());
      n_out++;
    end
    if (a) sb.push_back(128'(M) * 128'(Q));
    tick();
  endtask

  task automatic one_shot(input string tag, input logic [23:0] m, input logic [23:0] q,
                          input logic [47:0] exp, input logic exp_hi, input logic [23:0] exp_mant);
    M = m; Q = q; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    chk({tag, " out_valid+1"}, 128'(out_valid), 128'(0));
    tick();
    chk({tag, " out_valid+2"}, 128'(out_valid), 128'(0));
    tick();
    chk({tag, " out_valid+3"}, 128'(out_valid), 128'(1));
    chk({tag, " R"}, 128'(R), 128'(exp));
`ifdef MUL_NORM_EN
    chk({tag, " norm_hi"}, 128'(norm_hi), 128'(exp_hi));
    chk({tag, " mant"}, 128'(mant), 128'(exp_mant));
`endif
    tick();
    chk({tag, " drained"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; M = '0; Q = '0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    iv54 = 1'b0; or54 = 1'b1; a54 = '0; b54 = '0;
    pm = '{24'd3, 24'd7, 24'h001000, 24'hABCDEF, 24'h123456};
    pq = '{24'd5, 24'd11, 24'h001000, 24'h000002, 24'h654321};

    // Reset state
    tick(); tick(); tick();
    in_valid = 1'b1;
    #1;
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset R", 128'(R), 128'(0));
    chk("reset in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    rstn = 1'b1;
    #1;
    chk("post-reset in_ready", 128'(in_ready), 128'(1));

    // Directed corners with latency checks
    one_shot("ones", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, 24'hFFFFFE);
    one_shot("msb",  24'h800000, 24'h800000, 48'h400000000000, 1'b0, 24'h800000);
    one_shot("zeroM", 24'h000000, 24'h5A5A5A, 48'h0, 1'b0, 24'h0);
    one_shot("zeroQ", 24'hFFFFFF, 24'h000000, 48'h0, 1'b0, 24'h0);

    // Back-to-back random stream at full throughput
    sb.delete(); n_out = 0; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      M = 24'($urandom); Q = 24'($urandom); in_valid = 1'b1;
      if (i >= 3) begin
        #1;
        chk("b2b out_valid", 128'(out_valid), 128'(1));
      end
      cyc24(acc);
      chk("b2b in_ready", 128'(acc), 128'(1));
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && n_out < 100; c++) cyc24(acc);
    chk("b2b count", 128'(n_out), 128'(100));

    // Stall with out_ready low, then drain in order
    sb.delete(); n_out = 0; out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 5);
      if (idx < 5) begin M = pm[idx]; Q = pq[idx]; end
      cyc24(acc);
      if (acc) idx++;
    end
    chk("stall accepts", 128'(idx), 128'(3));
    in_valid = 1'b1; M = pm[3]; Q = pq[3];
    #1;
    chk("stall in_ready", 128'(in_ready), 128'(0));
    chk("stall out_valid", 128'(out_valid), 128'(1));
    chk("stall R held", 128'(R), 128'(15));
    out_ready = 1'b1;
    #1;
    chk("full pass-through in_ready", 128'(in_ready), 128'(1));
    for (int c = 0; c < 20 && n_out < 5; c++) begin
      in_valid = (idx < 5);
      if (idx < 5) begin M = pm[idx]; Q = pq[idx]; end
      cyc24(acc);
      if (acc) idx++;
    end
    chk("stall drain count", 128'(n_out), 128'(5));

    // Reset with two products in flight
    sb.delete(); out_ready = 1'b0;
    M = 24'h111111; Q = 24'h000002; in_valid = 1'b1; cyc24(acc);
    M = 24'h000003; Q = 24'h000003; cyc24(acc);
    in_valid = 1'b0; rstn = 1'b0;
    #1;
    chk("rst in_ready low", 128'(in_ready), 128'(0));
    tick();
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst R", 128'(R), 128'(0));
    rstn = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst no ghost", 128'(out_valid), 128'(0));
    end
    one_shot("after-rst", 24'h000ABC, 24'h000DEF, 48'h000000959184, 1'b0, 24'h000001);

    // N=8 sweep under random backpressure
    sb.delete(); n_in = 0; n_out = 0; a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
    for (int c = 0; c < 3000 && n_out < NP8; c++) begin
      or8 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov8 && or8) begin
        chk("n8 unexpected output", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) chk("n8 R", 128'(r8), sb.pop_front());
        n_out++;
      end
      acc = iv8 && ir8;
      if (acc) begin sb.push_back(128'(a8) * 128'(b8)); n_in++; end
      tick();
      if (acc) begin
        a8 = (n_in == 1) ? 8'h00 : 8'($urandom);
        b8 = 8'($urandom);
        iv8 = (n_in < NP8);
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    chk("n8 count", 128'(n_out), 128'(NP8));

    // N=54 sweep under random backpressure
    sb.delete(); n_in = 0; n_out = 0; a54 = '1; b54 = '1; iv54 = 1'b1;
    for (int c = 0; c < 2000 && n_out < NP54; c++) begin
      or54 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov54 && or54) begin
        chk("n54 unexpected output", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) chk("n54 R", 128'(r54), sb.pop_front());
        n_out++;
      end
      acc = iv54 && ir54;
      if (acc) begin sb.push_back(128'(a54) * 128'(b54)); n_in++; end
      tick();
      if (acc) begin
        a54 = 54'({$urandom, $urandom});
        b54 = (n_in == 1) ? 54'h0 : 54'({$urandom, $urandom});
        iv54 = (n_in < NP54);
      end
    end
    iv54 = 1'b0; or54 = 1'b1;
    chk("n54 count", 128'(n_out), 128'(NP54));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
